mem_bus_slave: RTL and testbench



---
 rtl/mem_bus_slave.sv | 183 ++++++++++++++++++
 tb/tb_mem_bus_slave.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_slave.sv
// Paged memory slave: answers dw/dr with rok/rdt over a 4-phase handshake, page map loaded by ds.
// Optional MEM_PARITY_EN stores odd parity per word and flags read mismatches on rpe.
module mem_bus_slave #(
    parameter logic [3:0] MODULE_NUMBER = 4'd0,
    parameter logic [4:0] FRAMES        = 5'd8,
    parameter logic [3:0] ACCESS_TICKS  = 4'd3
) (
    input  logic        __clk,
    input  logic        clm,
    input  logic        dw,
    input  logic        dr,
    input  logic        ds,
    input  logic [3:0]  dnb,
    input  logic [15:0] dad,
    input  logic [15:0] ddt,
    output logic        rok,
    output logic        rpe,
    output logic [15:0] rdt
);
    localparam int unsigned FW    = (FRAMES <= 5'd2) ? 32'd1 : 32'($clog2(FRAMES));
    localparam int unsigned AW    = FW + 32'd12;
    localparam int unsigned DEPTH = 32'd1 << AW;
`ifdef MEM_PARITY_EN
    localparam int unsigned DW = 17;
`else
    localparam int unsigned DW = 16;
`endif

    typedef enum logic [1:0] {IDLE, LOOKUP, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {K_W, K_R, K_S} kind_t;

    state_t         state;
    kind_t          kind;
    logic [3:0]     dnb_q;
    logic [15:0]    dad_q;
    logic [15:0]    ddt_q;
    logic [3:0]     cnt;
    logic           armed;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  ram_q;
    logic           map_valid [256];
    logic [3:0]     map_frame [256];

    logic           any_stb;
    logic           one_stb;
    logic           held;
    logic           hit;
    logic           cfg_hit;
    logic           first;
    logic           ram_we;
    logic           map_we;
    logic           resp_go;
    logic           rel_go;
    logic [7:0]     idx;
    logic [7:0]     cfg_idx;
    logic [DW-1:0]  wdata;

    // Strobe decode and per-transaction qualifiers
    always_comb begin
        any_stb = dw | dr | ds;
        one_stb = 1'b0;
        case ({dw, dr, ds})
            3'b100, 3'b010, 3'b001: one_stb = 1'b1;
            default:                one_stb = 1'b0;
        endcase
        held = 1'b0;
        case (kind)
            K_W:     held = dw;
            K_R:     held = dr;
            K_S:     held = ds;
            default: held = 1'b0;
        endcase
        idx     = {dnb_q, dad_q[15:12]};
        cfg_idx = {ddt_q[3:0], ddt_q[15:12]};
        hit     = map_valid[idx] && ({1'b0, map_frame[idx]} < FRAMES);
        cfg_hit = dad_q[0] && (dad_q[4:1] == MODULE_NUMBER);
        first   = (state == ACCESS) && (cnt == ACCESS_TICKS) && held;
        ram_we  = first && (kind == K_W) && !clm;
        map_we  = first && (kind == K_S) && !clm;
        resp_go = (state == ACCESS) && held && (cnt == 4'd0);
        rel_go  = (state == RESP) && !any_stb;
`ifdef MEM_PARITY_EN
        wdata   = {~^ddt_q, ddt_q};
`else
        wdata   = ddt_q;
`endif
    end

    // Page map: clm restores the two boot pages, ds configuration rewrites one entry
    always_ff @(posedge __clk) begin
        if (clm) begin
            for (int i = 0; i < 256; i++) begin
                map_valid[i] <= (i < 2);
                map_frame[i] <= (i == 1) ? 4'd1 : 4'd0;
            end
        end else if (map_we) begin
            map_valid[cfg_idx] <= ~ddt_q[7];
            map_frame[cfg_idx] <= ddt_q[11:8];
        end
    end

    // Synchronous RAM, contents survive clm
    always_ff @(posedge __clk) begin
        if (ram_we) begin
            mem[addr_q] <= wdata;
        end
        ram_q <= mem[addr_q];
    end

    // Handshake FSM; armed blocks a restart until all strobes have been seen low
    always_ff @(posedge __clk) begin
        if (clm) begin
            state  <= IDLE;
            kind   <= K_W;
            dnb_q  <= 4'd0;
            dad_q  <= 16'd0;
            ddt_q  <= 16'd0;
            cnt    <= 4'd0;
            armed  <= 1'b0;
            addr_q <= '0;
            rok    <= 1'b0;
            rdt    <= 16'd0;
        end else begin
            armed <= ~any_stb;
            case (state)
                IDLE: begin
                    if (armed && one_stb) begin
                        state <= LOOKUP;
                        kind  <= dw ? K_W : (dr ? K_R : K_S);
                        dnb_q <= dnb;
                        dad_q <= dad;
                        ddt_q <= ddt;
                    end
                end
                LOOKUP: begin
                    addr_q <= {map_frame[idx][FW-1:0], dad_q[11:0]};
                    cnt    <= ACCESS_TICKS;
                    if (held && ((kind == K_S) ? cfg_hit : hit)) begin
                        state <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (!held) begin
                        state <= IDLE;
                    end else if (resp_go) begin
                        state <= RESP;
                        rok   <= 1'b1;
                        rdt   <= (kind == K_R) ? ram_q[15:0] : 16'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rel_go) begin
                        state <= IDLE;
                        rok   <= 1'b0;
                        rdt   <= 16'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PARITY_EN
    // Parity error reported only on read answers
    always_ff @(posedge __clk) begin
        if (clm) begin
            rpe <= 1'b0;
        end else if (resp_go) begin
            rpe <= (kind == K_R) && ~^ram_q;
        end else if (rel_go) begin
            rpe <= 1'b0;
        end
    end
`else
    assign rpe = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_slave.sv
// Self-checking bench for mem_bus_slave: vector table plus scoreboard, with hand-written clm/parity cases.
module tb_mem_bus_slave;
    localparam logic [3:0] MN  = 4'd0;
    localparam logic [3:0] AT  = 4'd3;
    localparam int         LAT = 3 + int'(AT);
    localparam logic [2:0] S_W = 3'b100;
    localparam logic [2:0] S_R = 3'b010;
    localparam logic [2:0] S_S = 3'b001;
`ifdef MEM_PARITY_EN
    localparam logic       PAR = 1'b1;
`else
    localparam logic       PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clm;
    logic        dw, dr, ds;
    logic [3:0]  dnb;
    logic [15:0] dad, ddt;
    logic        rok, rpe;
    logic [15:0] rdt;

    typedef struct packed {
        logic [2:0]  stb;
        logic [3:0]  dnb;
        logic [15:0] dad;
        logic [15:0] ddt;
        logic        exp_ok;
        logic [15:0] exp_rdt;
        logic        exp_rpe;
    } vec_t;

    typedef struct packed {
        logic        ok;
        logic [15:0] rdt;
        logic        rpe;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bus_slave #(
        .MODULE_NUMBER(MN),
        .FRAMES(5'd8),
        .ACCESS_TICKS(AT)
    ) dut (
        .__clk(clk),
        .clm(clm),
        .dw(dw),
        .dr(dr),
        .ds(ds),
        .dnb(dnb),
        .dad(dad),
        .ddt(ddt),
        .rok(rok),
        .rpe(rpe),
        .rdt(rdt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] stb, input logic [3:0] nb, input logic [15:0] ad,
                                input logic [15:0] dt, input logic ok, input logic [15:0] rd,
                                input logic pe);
        vec_t v;
        v.stb = stb; v.dnb = nb; v.dad = ad; v.ddt = dt;
        v.exp_ok = ok; v.exp_rdt = rd; v.exp_rpe = pe;
        return v;
    endfunction

    // One transaction: starts and ends on a falling edge
    task automatic run_vec(input vec_t v, input int id);
        exp_t e;
        int   n;
        bit   got;
        string tag;
        tag = $sformatf("vec%0d", id);
        sb_q.push_back('{v.exp_ok, v.exp_rdt, v.exp_rpe});
        {dw, dr, ds} = v.stb;
        dnb = v.dnb; dad = v.dad; ddt = v.ddt;
        n = 0; got = 1'b0;
        while (!got && n < (v.exp_ok ? 64 : 1000)) begin
            @(negedge clk);
            n++;
            if (rok) got = 1'b1;
        end
        e = sb_q.pop_front();
        check({tag, " rok"}, 32'(got), 32'(e.ok));
        if (e.ok && got) begin
            check({tag, " latency"}, 32'(n), 32'(LAT));
            check({tag, " rdt"}, 32'(rdt), 32'(e.rdt));
            check({tag, " rpe"}, 32'(rpe), 32'(e.rpe));
        end else begin
            check({tag, " rdt idle"}, 32'(rdt), 32'd0);
        end
        {dw, dr, ds} = 3'b000;
        @(negedge clk);
        if (got) begin
            check({tag, " release"}, {15'd0, rok, rdt}, 32'd0);
            check({tag, " release rpe"}, 32'(rpe), 32'd0);
        end
        @(negedge clk);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        clm = 1'b1; dw = 1'b0; dr = 1'b0; ds = 1'b0;
        dnb = 4'd0; dad = 16'd0; ddt = 16'd0;
        repeat (3) @(negedge clk);
        check("reset rok", 32'(rok), 32'd0);
        check("reset rpe", 32'(rpe), 32'd0);
        check("reset rdt", 32'(rdt), 32'd0);
        clm = 1'b0;
        repeat (2) @(negedge clk);

        vecs = {};
        vecs.push_back(mk(S_W, 4'd0, 16'h0123, 16'hBEEF, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h0123, 16'h0000, 1'b1, 16'hBEEF, 1'b0));
        vecs.push_back(mk(S_W, 4'd0, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd3, 16'h5000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_S, 4'd0, 16'h8001 | {11'd0, MN, 1'b0}, 16'h5203, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_W, 4'd3, 16'h5000, 16'hCAFE, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd3, 16'h5000, 16'h0000, 1'b1, 16'hCAFE, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0));
        vecs.push_back(mk(S_S, 4'd0, 16'h8001 | {11'd0, 4'(MN + 4'd1), 1'b0}, 16'h6304, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd4, 16'h6000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_S, 4'd0, 16'h8001 | {11'd0, MN, 1'b0}, 16'h7805, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd5, 16'h7000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_S, 4'd0, 16'h8001 | {11'd0, MN, 1'b0}, 16'h1306, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_W, 4'd6, 16'h1000, 16'h5A5A, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd6, 16'h1000, 16'h0000, 1'b1, 16'h5A5A, 1'b0));
        vecs.push_back(mk(S_S, 4'd0, 16'h8001 | {11'd0, MN, 1'b0}, 16'h1386, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd6, 16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_W, 4'd0, 16'h0005, 16'h1111, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_W, 4'd0, 16'h1005, 16'h2222, 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h0005, 16'h0000, 1'b1, 16'h1111, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h1005, 16'h0000, 1'b1, 16'h2222, 1'b0));
        vecs.push_back(mk(S_W | S_R, 4'd0, 16'h0123, 16'h0BAD, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h0123, 16'h0000, 1'b1, 16'hBEEF, 1'b0));
        run_table();

        // clm during ACCESS of a read aborts it; held strobe must not restart a transaction
        dr = 1'b1; dnb = 4'd0; dad = 16'h0123;
        repeat (2) @(negedge clk);
        clm = 1'b1;
        @(negedge clk);
        check("clm rok", 32'(rok), 32'd0);
        check("clm rdt", 32'(rdt), 32'd0);
        clm = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rok) seen = 1'b1;
        end
        check("clm no restart", 32'(seen), 32'd0);
        dr = 1'b0;
        repeat (2) @(negedge clk);

        vecs = {};
        vecs.push_back(mk(S_R, 4'd3, 16'h5000, 16'h0000, 1'b0, 16'h0000, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h0123, 16'h0000, 1'b1, 16'hBEEF, 1'b0));
        vecs.push_back(mk(S_R, 4'd0, 16'h1005, 16'h0000, 1'b1, 16'h2222, 1'b0));
        vecs.push_back(mk(S_W, 4'd0, 16'h0007, 16'h0F0F, 1'b1, 16'h0000, 1'b0));
        run_table();

`ifdef MEM_PARITY_EN
        dut.mem[7][16] = ~dut.mem[7][16];
`endif
        run_vec(mk(S_R, 4'd0, 16'h0007, 16'h0000, 1'b1, 16'h0F0F, PAR), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
